// File: rtl/axis_stream_reader.sv
// axis_stream_reader
// AXI-stream sink endpoint. Incoming beats {TLAST, TKEEP, TDATA} are buffered
// in a FIFO and popped by local control logic through a simple read port.
// A small FSM tracks the byte count of each packet. It reports the count and
// a done pulse when TLAST is accepted. A sticky err flag records TKEEP
// protocol violations and byte-count saturation.
//
// Ports:
//   ACLK, ARESETN        clock (rising edge), asynchronous active-low reset
//   s_T*                 AXI-stream slave: TDATA, TKEEP, TLAST, TVALID, TREADY
//   rd_en                pop request; ignored while the FIFO is empty
//   rd_valid, rd_*       popped beat, valid one cycle after rd_en
//   level                current FIFO occupancy
//   pkt_done, pkt_bytes  completion pulse and byte count of last packet
//   err, err_clr         sticky protocol error and its clear (set wins)
module axis_stream_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 16,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                          ACLK,
    input  logic                          ARESETN,
    input  logic [DATA_WIDTH-1:0]         s_TDATA,
    input  logic [DATA_WIDTH/8-1:0]       s_TKEEP,
    input  logic                          s_TLAST,
    input  logic                          s_TVALID,
    output logic                          s_TREADY,
    input  logic                          rd_en,
    output logic                          rd_valid,
    output logic [DATA_WIDTH-1:0]         rd_data,
    output logic [DATA_WIDTH/8-1:0]       rd_keep,
    output logic                          rd_last,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          pkt_done,
    output logic [LEN_WIDTH-1:0]          pkt_bytes,
    output logic                          err,
    input  logic                          err_clr
);

    localparam int KW = DATA_WIDTH / 8;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int EW = 1 + KW + DATA_WIDTH;

    typedef enum logic {IDLE, IN_PKT} state_t;

    // Number of valid bytes in a keep mask.
    function automatic logic [LEN_WIDTH-1:0] popcount(input logic [KW-1:0] k);
        logic [LEN_WIDTH-1:0] n;
        n = '0;
        for (int i = 0; i < KW; i++) n = n + LEN_WIDTH'(k[i]);
        return n;
    endfunction

    // Saturating add; MSB of the result flags that saturation occurred.
    function automatic logic [LEN_WIDTH:0] sat_add(input logic [LEN_WIDTH-1:0] a,
                                                   input logic [LEN_WIDTH-1:0] b);
        logic [LEN_WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s[LEN_WIDTH]) return {1'b1, {LEN_WIDTH{1'b1}}};
        return s;
    endfunction

    logic [EW-1:0]        mem [FIFO_DEPTH];
    logic [AW-1:0]        wptr, rptr;
    logic [LW-1:0]        level_nxt;
    logic                 push, pop;
    state_t               state, state_nxt;
    logic [LEN_WIDTH-1:0] cnt, cnt_nxt;
    logic                 done_set, sat_err, err_set;
    logic [KW-1:0]        keep_p1;
    logic                 keep_bad;

    assign push = s_TVALID & s_TREADY;
    assign pop  = rd_en & (level != '0);

    always_comb begin
        level_nxt = level;
        case ({push, pop})
            2'b10:   level_nxt = level + LW'(1);
            2'b01:   level_nxt = level - LW'(1);
            default: level_nxt = level;
        endcase
    end

    // FIFO storage: no reset needed, occupancy is tracked by pointers/level.
    always_ff @(posedge ACLK) begin
        if (push) mem[wptr] <= {s_TLAST, s_TKEEP, s_TDATA};
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wptr     <= '0;
            rptr     <= '0;
            level    <= '0;
            s_TREADY <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            rd_keep  <= '0;
            rd_last  <= 1'b0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            level    <= level_nxt;
            s_TREADY <= (level_nxt != LW'(FIFO_DEPTH));
            rd_valid <= pop;
            if (pop) {rd_last, rd_keep, rd_data} <= mem[rptr];
        end
    end

    // Byte-count FSM: state register
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) state <= IDLE;
        else          state <= state_nxt;
    end

    // Byte-count FSM: next state
    always_comb begin
        state_nxt = state;
        if (push) begin
            case (state)
                IDLE:    if (!s_TLAST) state_nxt = IN_PKT;
                IN_PKT:  if (s_TLAST)  state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Byte-count FSM: outputs (running count update and completion)
    always_comb begin
        cnt_nxt  = cnt;
        sat_err  = 1'b0;
        done_set = 1'b0;
        if (push) begin
            if (state == IDLE) cnt_nxt = popcount(s_TKEEP);
            else               {sat_err, cnt_nxt} = sat_add(cnt, popcount(s_TKEEP));
            done_set = s_TLAST;
        end
    end

    // Legal keep is a non-zero run of ones from byte 0, all-ones unless TLAST.
    // x & (x+1) is zero exactly when x has the form 0..01..1.
    always_comb begin
        keep_p1  = s_TKEEP + KW'(1);
        keep_bad = ((s_TKEEP & keep_p1) != '0) || (s_TKEEP == '0) ||
                   (!s_TLAST && (s_TKEEP != '1));
    end

    assign err_set = push & (keep_bad | sat_err);

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            cnt       <= '0;
            pkt_bytes <= '0;
            pkt_done  <= 1'b0;
            err       <= 1'b0;
        end else begin
            cnt      <= cnt_nxt;
            pkt_done <= done_set;
            if (done_set) pkt_bytes <= cnt_nxt;
            if (err_set)      err <= 1'b1;
            else if (err_clr) err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axis_stream_reader.sv
module tb_axis_stream_reader;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic [31:0] s_TDATA = '0;
    logic [3:0]  s_TKEEP = '0;
    logic        s_TLAST = 1'b0;
    logic        s_TVALID = 1'b0;
    logic        s_TREADY;
    logic        rd_en = 1'b0;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic [3:0]  rd_keep;
    logic        rd_last;
    logic [4:0]  level;
    logic        pkt_done;
    logic [15:0] pkt_bytes;
    logic        err;
    logic        err_clr = 1'b0;

    int checks = 0;
    int errors = 0;

    axis_stream_reader #(.DATA_WIDTH(32), .FIFO_DEPTH(16), .LEN_WIDTH(16)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .s_TDATA(s_TDATA), .s_TKEEP(s_TKEEP), .s_TLAST(s_TLAST),
        .s_TVALID(s_TVALID), .s_TREADY(s_TREADY),
        .rd_en(rd_en), .rd_valid(rd_valid), .rd_data(rd_data),
        .rd_keep(rd_keep), .rd_last(rd_last), .level(level),
        .pkt_done(pkt_done), .pkt_bytes(pkt_bytes),
        .err(err), .err_clr(err_clr)
    );

    always #5 ACLK = ~ACLK;

    // Advance one clock; outputs are then stable and reflect that edge.
    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        s_TVALID = 1'b1; s_TDATA = d; s_TKEEP = k; s_TLAST = l;
    endtask

    task automatic idle_in();
        s_TVALID = 1'b0; s_TDATA = '0; s_TKEEP = '0; s_TLAST = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        idle_in();
        rd_en = 1'b1;
        while (level != 0 && n < 40) begin step(); n++; end
        rd_en = 1'b0;
        step();
        checks++;
        if (level !== 5'd0) begin errors++; $display("FAIL drain_timeout level=%0d required 0", level); end
    endtask

    task automatic test_reset();
        ARESETN = 1'b0;
        step(); step();
        checks++; if (s_TREADY !== 1'b0) begin errors++; $display("FAIL rst_tready got %b exp 0", s_TREADY); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rst_rd_valid got %b exp 0", rd_valid); end
        checks++; if (rd_data !== 32'd0) begin errors++; $display("FAIL rst_rd_data got %h exp 0", rd_data); end
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL rst_level got %0d exp 0", level); end
        checks++; if (pkt_done !== 1'b0) begin errors++; $display("FAIL rst_pkt_done got %b exp 0", pkt_done); end
        checks++; if (pkt_bytes !== 16'd0) begin errors++; $display("FAIL rst_pkt_bytes got %0d exp 0", pkt_bytes); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", err); end
        ARESETN = 1'b1;
        step();
        checks++; if (s_TREADY !== 1'b1) begin errors++; $display("FAIL rel_tready got %b exp 1", s_TREADY); end
    endtask

    task automatic test_packet();
        beat(32'hA0, 4'hF, 1'b0); step();
        checks++; if (pkt_done !== 1'b0) begin errors++; $display("FAIL pkt_done_b1 got %b exp 0", pkt_done); end
        beat(32'hA1, 4'hF, 1'b0); step();
        checks++; if (pkt_done !== 1'b0) begin errors++; $display("FAIL pkt_done_b2 got %b exp 0", pkt_done); end
        beat(32'hA2, 4'h3, 1'b1); step();
        idle_in();
        checks++; if (pkt_done !== 1'b1) begin errors++; $display("FAIL pkt_done_b3 got %b exp 1", pkt_done); end
        checks++; if (pkt_bytes !== 16'd10) begin errors++; $display("FAIL pkt_bytes got %0d exp 10", pkt_bytes); end
        checks++; if (level !== 5'd3) begin errors++; $display("FAIL pkt_level got %0d exp 3", level); end
        step();
        checks++; if (pkt_done !== 1'b0) begin errors++; $display("FAIL pkt_done_once got %b exp 0", pkt_done); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL pkt_err got %b exp 0", err); end
        rd_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== 32'hA0 + i) begin
                errors++; $display("FAIL pkt_pop%0d got v=%b d=%h exp v=1 d=%h", i, rd_valid, rd_data, 32'hA0 + i);
            end
        end
        checks++; if (rd_keep !== 4'h3 || rd_last !== 1'b1) begin errors++; $display("FAIL pkt_pop_tail got k=%h l=%b exp k=3 l=1", rd_keep, rd_last); end
        rd_en = 1'b0;
        step();
    endtask

    task automatic test_full();
        for (int i = 0; i < 16; i++) begin
            beat(32'h100 + i, 4'hF, i == 15);
            step();
            if (i == 14) begin
                checks++; if (s_TREADY !== 1'b1) begin errors++; $display("FAIL full_tready15 got %b exp 1", s_TREADY); end
            end
        end
        idle_in();
        checks++; if (s_TREADY !== 1'b0) begin errors++; $display("FAIL full_tready got %b exp 0", s_TREADY); end
        checks++; if (level !== 5'd16) begin errors++; $display("FAIL full_level got %0d exp 16", level); end
        checks++; if (pkt_done !== 1'b1 || pkt_bytes !== 16'd64) begin errors++; $display("FAIL full_pkt got d=%b n=%0d exp d=1 n=64", pkt_done, pkt_bytes); end
        step();
        checks++; if (s_TREADY !== 1'b0) begin errors++; $display("FAIL full_hold_tready got %b exp 0", s_TREADY); end
        rd_en = 1'b1; step(); rd_en = 1'b0;
        checks++; if (rd_valid !== 1'b1 || rd_data !== 32'h100) begin errors++; $display("FAIL full_pop got v=%b d=%h exp v=1 d=100", rd_valid, rd_data); end
        checks++; if (s_TREADY !== 1'b1) begin errors++; $display("FAIL full_tready_after_pop got %b exp 1", s_TREADY); end
        checks++; if (level !== 5'd15) begin errors++; $display("FAIL full_level_after_pop got %0d exp 15", level); end
        step();
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL full_rd_valid_drop got %b exp 0", rd_valid); end
        drain();
    endtask

    task automatic test_back_to_back();
        rd_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            beat(i, 4'hF, i == 39);
            step();
            checks++; if (level > 5'd1) begin errors++; $display("FAIL b2b_level%0d got %0d exp <=1", i, level); end
            if (i >= 1) begin
                checks++;
                if (rd_valid !== 1'b1 || rd_data !== i - 1) begin
                    errors++; $display("FAIL b2b_data%0d got v=%b d=%0d exp v=1 d=%0d", i, rd_valid, rd_data, i - 1);
                end
            end
        end
        checks++; if (pkt_done !== 1'b1 || pkt_bytes !== 16'd160) begin errors++; $display("FAIL b2b_pkt got d=%b n=%0d exp d=1 n=160", pkt_done, pkt_bytes); end
        idle_in();
        step();
        checks++; if (rd_valid !== 1'b1 || rd_data !== 32'd39) begin errors++; $display("FAIL b2b_last got v=%b d=%0d exp v=1 d=39", rd_valid, rd_data); end
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL b2b_end_level got %0d exp 0", level); end
        rd_en = 1'b0;
        step();
    endtask

    task automatic test_errors();
        beat(32'hE0, 4'h5, 1'b1); step(); idle_in();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_keep5 got %b exp 1", err); end
        checks++; if (pkt_bytes !== 16'd2) begin errors++; $display("FAIL err_keep5_bytes got %0d exp 2", pkt_bytes); end
        err_clr = 1'b1; step(); err_clr = 1'b0;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clr1 got %b exp 0", err); end
        beat(32'hE1, 4'h7, 1'b0); step();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_keep7_nolast got %b exp 1", err); end
        beat(32'hE2, 4'hF, 1'b1); step(); idle_in();
        checks++; if (pkt_bytes !== 16'd7) begin errors++; $display("FAIL err_pkt7_bytes got %0d exp 7", pkt_bytes); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b exp 1", err); end
        err_clr = 1'b1; step(); err_clr = 1'b0;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clr2 got %b exp 0", err); end
        beat(32'hE3, 4'h0, 1'b1); err_clr = 1'b1; step(); err_clr = 1'b0; idle_in();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_set_wins got %b exp 1", err); end
        checks++; if (level !== 5'd4) begin errors++; $display("FAIL err_stored_level got %0d exp 4", level); end
        rd_en = 1'b1; step(); rd_en = 1'b0;
        checks++; if (rd_data !== 32'hE0 || rd_keep !== 4'h5 || rd_last !== 1'b1) begin errors++; $display("FAIL err_stored got d=%h k=%h l=%b exp d=e0 k=5 l=1", rd_data, rd_keep, rd_last); end
        drain();
        err_clr = 1'b1; step(); err_clr = 1'b0;
    endtask

    task automatic test_empty_read();
        rd_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (rd_valid !== 1'b0 || level !== 5'd0) begin errors++; $display("FAIL empty_rd%0d got v=%b lvl=%0d exp v=0 lvl=0", i, rd_valid, level); end
        end
        rd_en = 1'b0;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL empty_rd_err got %b exp 0", err); end
    endtask

    task automatic test_reset_mid();
        beat(32'hC0, 4'hF, 1'b0); step();
        beat(32'hC1, 4'hF, 1'b0); step();
        idle_in();
        ARESETN = 1'b0;
        #1;
        checks++; if (level !== 5'd0 || rd_valid !== 1'b0 || pkt_done !== 1'b0) begin errors++; $display("FAIL mid_rst got lvl=%0d v=%b d=%b exp 0 0 0", level, rd_valid, pkt_done); end
        step();
        ARESETN = 1'b1;
        step();
        checks++; if (pkt_done !== 1'b0 || s_TREADY !== 1'b1) begin errors++; $display("FAIL mid_rel got d=%b rdy=%b exp d=0 rdy=1", pkt_done, s_TREADY); end
        for (int i = 0; i < 4; i++) begin
            beat(32'hD0 + i, (i == 3) ? 4'h1 : 4'hF, i == 3);
            step();
            if (i < 3) begin
                checks++; if (pkt_done !== 1'b0) begin errors++; $display("FAIL mid_early_done%0d got %b exp 0", i, pkt_done); end
            end
        end
        idle_in();
        checks++; if (pkt_done !== 1'b1 || pkt_bytes !== 16'd13) begin errors++; $display("FAIL mid_pkt got d=%b n=%0d exp d=1 n=13", pkt_done, pkt_bytes); end
        rd_en = 1'b1; step(); rd_en = 1'b0;
        checks++; if (rd_data !== 32'hD0) begin errors++; $display("FAIL mid_first_pop got %h exp d0", rd_data); end
        drain();
    endtask

    initial begin
        test_reset();
        test_packet();
        test_full();
        test_back_to_back();
        test_errors();
        test_empty_read();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
